// File: rtl/data_cache_v2_if.sv
// Packet, verdict, flow-control and localbus signals of the data cache.
// master = upstream/bus driver side, slave = the cache itself.
interface data_cache_v2_if #(
  parameter int DATA_W = 134
) ();
  logic              in_data_wr;
  logic [DATA_W-1:0] in_data;
  logic              in_valid_wr;
  logic              in_valid;
  logic              out_alf;
  logic              out_data_wr;
  logic [DATA_W-1:0] out_data;
  logic              out_valid_wr;
  logic              out_valid;
  logic              in_alf;
  logic              cfg_cs_n;
  logic              cfg_ack_n;
  logic              cfg_rw;
  logic [31:0]       cfg_addr;
  logic [31:0]       cfg_wdata;
  logic [31:0]       cfg_rdata;

  modport master (
    output in_data_wr, in_data, in_valid_wr, in_valid, in_alf,
           cfg_cs_n, cfg_rw, cfg_addr, cfg_wdata,
    input  out_alf, out_data_wr, out_data, out_valid_wr, out_valid,
           cfg_ack_n, cfg_rdata
  );

  modport slave (
    input  in_data_wr, in_data, in_valid_wr, in_valid, in_alf,
           cfg_cs_n, cfg_rw, cfg_addr, cfg_wdata,
    output out_alf, out_data_wr, out_data, out_valid_wr, out_valid,
           cfg_ack_n, cfg_rdata
  );
endinterface

// File: rtl/data_cache_v2.sv
// Packet cache: data FIFO + verdict FIFO, forwards or discards whole packets, localbus config.
// Define DATA_CACHE_STATS_EN to build the in_pkt/out_pkt/drop counters (else they read 0).
module data_cache_v2 #(
  parameter int DATA_W      = 134,
  parameter int DDEPTH_LOG2 = 10,
  parameter int VDEPTH_LOG2 = 8,
  parameter int ALF_MARGIN  = 512
) (
  input  logic            clk,
  input  logic            rst_n,
  data_cache_v2_if.slave  bus
);
  localparam int DD = 2**DDEPTH_LOG2;
  localparam int VD = 2**VDEPTH_LOG2;

  typedef enum logic [1:0] {P_IDLE = 2'd0, P_SEND = 2'd1, P_DISCARD = 2'd2} pstate_t;
  typedef enum logic [2:0] {C_IDLE, C_WRITE, C_READ, C_WAIT, C_ACK} cstate_t;

  function automatic logic is_tail(input logic [DATA_W-1:0] w);
    return w[DATA_W-1:DATA_W-2] == 2'b10;
  endfunction

  logic [DATA_W-1:0]      dmem [DD];
  logic [DDEPTH_LOG2-1:0] dwp, drp;
  logic [DDEPTH_LOG2:0]   dused;
  logic                   vmem [VD];
  logic [VDEPTH_LOG2-1:0] vwp, vrp;
  logic [VDEPTH_LOG2:0]   vused;
  logic dfull, dempty, dwr, dpop, vfull, vempty, vwr, vpop;
  logic [DATA_W-1:0]      dhead;
  logic                   vhead;

  logic                   force_discard, ovf, alf;
  logic [DDEPTH_LOG2:0]   margin;
  logic [DDEPTH_LOG2+1:0] alf_sum;

  assign dfull  = dused == (DDEPTH_LOG2+1)'(DD);
  assign dempty = dused == '0;
  assign vfull  = vused == (VDEPTH_LOG2+1)'(VD);
  assign vempty = vused == '0;
  assign dwr    = bus.in_data_wr && !dfull;
  assign vwr    = bus.in_valid_wr && !vfull;
  assign dhead  = dmem[drp];
  assign vhead  = vmem[vrp];

  always_ff @(posedge clk) begin
    if (dwr) dmem[dwp] <= bus.in_data;
    if (vwr) vmem[vwp] <= bus.in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwp <= '0; drp <= '0; dused <= '0;
      vwp <= '0; vrp <= '0; vused <= '0;
    end else begin
      if (dwr)  dwp <= dwp + 1'b1;
      if (dpop) drp <= drp + 1'b1;
      if (dwr && !dpop)      dused <= dused + 1'b1;
      else if (!dwr && dpop) dused <= dused - 1'b1;
      if (vwr)  vwp <= vwp + 1'b1;
      if (vpop) vrp <= vrp + 1'b1;
      if (vwr && !vpop)      vused <= vused + 1'b1;
      else if (!vwr && vpop) vused <= vused - 1'b1;
    end
  end

  // Margin is added rather than subtracted so an oversized margin simply keeps alf high.
  assign alf_sum = {1'b0, dused} + {1'b0, margin};
  assign alf     = (alf_sum >= (DDEPTH_LOG2+2)'(DD)) || (vused >= (VDEPTH_LOG2+1)'(VD-2));
  assign bus.out_alf = alf;

  pstate_t           pstate, pnext;
  logic              vld_p0, tail_p0, drop_evt;
  logic              vld_p1, tail_p1;
  logic [DATA_W-1:0] data_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pstate <= P_IDLE;
    else        pstate <= pnext;
  end

  always_comb begin
    pnext    = pstate;
    dpop     = 1'b0;
    vpop     = 1'b0;
    vld_p0   = 1'b0;
    tail_p0  = 1'b0;
    drop_evt = 1'b0;
    unique case (pstate)
      P_IDLE: begin
        if (!vempty) begin
          if (!vhead || force_discard) pnext = P_DISCARD;
          else if (!bus.in_alf)        pnext = P_SEND;
        end
      end
      P_SEND: begin
        if (!dempty) begin
          dpop   = 1'b1;
          vld_p0 = 1'b1;
          if (is_tail(dhead)) begin
            tail_p0 = 1'b1;
            vpop    = 1'b1;
            pnext   = P_IDLE;
          end
        end
      end
      P_DISCARD: begin
        if (!dempty) begin
          dpop = 1'b1;
          if (is_tail(dhead)) begin
            vpop     = 1'b1;
            drop_evt = 1'b1;
            pnext    = P_IDLE;
          end
        end
      end
      default: pnext = P_IDLE;
    endcase
  end

  // p0 -> p1: registered output word and strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      tail_p1 <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      tail_p1 <= tail_p0;
      if (vld_p0) data_p1 <= dhead;
    end
  end

  assign bus.out_data_wr  = vld_p1;
  assign bus.out_data     = data_p1;
  assign bus.out_valid_wr = tail_p1;
  assign bus.out_valid    = tail_p1;

  logic       cs_s1, cs_s2, ack_entry, ack_n_q;
  logic [7:0] reg_sel;
  logic [31:0] rmux, rdata_q;
  cstate_t    cstate, cnext;

  assign reg_sel   = bus.cfg_addr[9:2];
  assign ack_entry = cstate == C_WAIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cstate  <= C_IDLE;
      ack_n_q <= 1'b1;
    end else begin
      cs_s1   <= bus.cfg_cs_n;
      cs_s2   <= cs_s1;
      cstate  <= cnext;
      ack_n_q <= cnext != C_ACK;
    end
  end

  always_comb begin
    cnext = cstate;
    unique case (cstate)
      C_IDLE:          if (!cs_s2) cnext = bus.cfg_rw ? C_READ : C_WRITE;
      C_WRITE, C_READ: cnext = C_WAIT;
      C_WAIT:          cnext = C_ACK;
      C_ACK:           if (cs_s2) cnext = C_IDLE;
      default:         cnext = C_IDLE;
    endcase
  end

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] in_pkt_cnt, out_pkt_cnt, drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pkt_cnt  <= '0;
      out_pkt_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (bus.in_valid_wr) in_pkt_cnt  <= in_pkt_cnt + 1'b1;
      if (tail_p0)         out_pkt_cnt <= out_pkt_cnt + 1'b1;
      if (drop_evt)        drop_cnt    <= drop_cnt + 1'b1;
    end
  end
`else
  wire unused_stats = drop_evt;
`endif

  always_comb begin
    rmux = '0;
    case (reg_sel)
      8'h00: rmux = {31'd0, force_discard};
      8'h01: rmux = {pstate, 27'd0, ovf, alf, bus.in_alf};
      8'h02: rmux = 32'(margin);
`ifdef DATA_CACHE_STATS_EN
      8'h03: rmux = in_pkt_cnt;
      8'h04: rmux = out_pkt_cnt;
      8'h05: rmux = drop_cnt;
`endif
      default: rmux = '0;
    endcase
  end

  // A new overflow in the same cycle as a W1C wins, so no event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      force_discard <= 1'b0;
      margin        <= (DDEPTH_LOG2+1)'(ALF_MARGIN);
      ovf           <= 1'b0;
      rdata_q       <= '0;
    end else begin
      if (ack_entry) begin
        rdata_q <= rmux;
        if (!bus.cfg_rw) begin
          case (reg_sel)
            8'h00:   force_discard <= bus.cfg_wdata[0];
            8'h02:   margin        <= bus.cfg_wdata[DDEPTH_LOG2:0];
            default: ;
          endcase
        end
      end
      if ((bus.in_data_wr && dfull) || (bus.in_valid_wr && vfull))
        ovf <= 1'b1;
      else if (ack_entry && !bus.cfg_rw && reg_sel == 8'h01 && bus.cfg_wdata[2])
        ovf <= 1'b0;
    end
  end

  assign bus.cfg_ack_n = ack_n_q;
  assign bus.cfg_rdata = rdata_q;

  wire unused_cfg = ^{bus.cfg_addr[31:10], bus.cfg_addr[1:0], bus.cfg_wdata};
endmodule

// File: tb/tb_data_cache_v2.sv
// Directed bench for data_cache_v2: register vector table plus packet-level sequences.
module tb_data_cache_v2;
  localparam int DW = 134;

`ifdef DATA_CACHE_STATS_EN
  localparam int ST = 1;
`else
  localparam int ST = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_cache_v2_if #(.DATA_W(DW)) bus ();

  data_cache_v2 #(.DATA_W(DW), .DDEPTH_LOG2(10), .VDEPTH_LOG2(8), .ALF_MARGIN(512)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          vwr;
    logic          v;
    int            cyc;
  } out_t;
  out_t mon_q[$];

  always @(negedge clk) begin
    if (rst_n && (bus.out_data_wr || bus.out_valid_wr))
      mon_q.push_back('{bus.out_data, bus.out_valid_wr, bus.out_valid, cyc});
  end

  typedef struct {
    logic        rw;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_word(input int n, input int tag, input int i);
    logic [1:0] t;
    t = (i == 0) ? 2'b01 : (i == n-1) ? 2'b10 : 2'b11;
    return {t, (DW-2)'(tag * 256 + i)};
  endfunction

  task automatic send_pkt(input int n, input int tag, input logic verdict);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.in_data_wr = 1'b1;
      bus.in_data    = mk_word(n, tag, i);
      if (i == n-1) begin
        bus.in_valid_wr = 1'b1;
        bus.in_valid    = verdict;
      end
    end
    @(posedge clk); #1;
    bus.in_data_wr  = 1'b0;
    bus.in_valid_wr = 1'b0;
    bus.in_valid    = 1'b0;
  endtask

  task automatic push_words(input int n, input int tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.in_data_wr = 1'b1;
      bus.in_data    = {2'b01, (DW-2)'(tag * 4096 + i)};
    end
    @(posedge clk); #1;
    bus.in_data_wr = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    int k = 0;
    while (mon_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
  endtask

  task automatic check_pkt(input string name, input int n, input int tag);
    chk($sformatf("%s_count", name), DW'(mon_q.size()), DW'(n));
    for (int i = 0; i < n && i < mon_q.size(); i++) begin
      chk($sformatf("%s_word%0d", name, i), mon_q[i].data, mk_word(n, tag, i));
      chk($sformatf("%s_vwr%0d", name, i), DW'(mon_q[i].vwr), DW'(i == n-1));
      if (i == n-1) chk($sformatf("%s_valid", name), DW'(mon_q[i].v), DW'(1));
      if (i > 0) chk($sformatf("%s_b2b%0d", name, i), DW'(mon_q[i].cyc), DW'(mon_q[0].cyc + i));
    end
  endtask

  task automatic cfg_xfer(input logic rw, input logic [7:0] a, input logic [31:0] wd,
                          output logic [31:0] rd);
    int k;
    @(posedge clk); #1;
    bus.cfg_cs_n  = 1'b0;
    bus.cfg_rw    = rw;
    bus.cfg_addr  = {22'd0, a, 2'b00};
    bus.cfg_wdata = wd;
    k = 0;
    do begin @(negedge clk); k++; end while (bus.cfg_ack_n !== 1'b0 && k < 40);
    if (bus.cfg_ack_n !== 1'b0) begin
      n_chk++; n_fail++;
      $display("FAIL cfg_ack_assert addr %0h: got ack_n=%b, required 0 within 40 cycles", a, bus.cfg_ack_n);
    end
    rd = bus.cfg_rdata;
    @(posedge clk); #1;
    bus.cfg_cs_n = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (bus.cfg_ack_n !== 1'b1 && k < 40);
    if (bus.cfg_ack_n !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL cfg_ack_release addr %0h: got ack_n=%b, required 1 within 40 cycles", a, bus.cfg_ack_n);
    end
  endtask

  task automatic reg_rd(input logic [7:0] a, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    cfg_xfer(1'b1, a, 32'd0, rd);
    chk(name, DW'(rd), DW'(exp));
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] wd);
    logic [31:0] rd;
    cfg_xfer(1'b0, a, wd, rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [31:0] rd;

    tbl[0]  = '{1'b1, 8'h00, 32'h0,        32'h0};
    tbl[1]  = '{1'b1, 8'h01, 32'h0,        32'h0};
    tbl[2]  = '{1'b1, 8'h02, 32'h0,        32'h200};
    tbl[3]  = '{1'b1, 8'h03, 32'h0,        32'h0};
    tbl[4]  = '{1'b1, 8'h04, 32'h0,        32'h0};
    tbl[5]  = '{1'b1, 8'h05, 32'h0,        32'h0};
    tbl[6]  = '{1'b0, 8'h00, 32'h1,        32'h0};
    tbl[7]  = '{1'b1, 8'h00, 32'h0,        32'h1};
    tbl[8]  = '{1'b0, 8'h00, 32'hFFFFFFFE, 32'h0};
    tbl[9]  = '{1'b1, 8'h00, 32'h0,        32'h0};
    tbl[10] = '{1'b0, 8'h02, 32'hFFFFF123, 32'h0};
    tbl[11] = '{1'b1, 8'h02, 32'h0,        32'h123};
    tbl[12] = '{1'b0, 8'h07, 32'hFFFFFFFF, 32'h0};
    tbl[13] = '{1'b1, 8'h07, 32'h0,        32'h0};
    tbl[14] = '{1'b0, 8'h02, 32'h200,      32'h0};
    tbl[15] = '{1'b1, 8'h02, 32'h0,        32'h200};

    bus.in_data_wr = 1'b0; bus.in_data = '0; bus.in_valid_wr = 1'b0; bus.in_valid = 1'b0;
    bus.in_alf = 1'b0; bus.cfg_cs_n = 1'b1; bus.cfg_rw = 1'b0;
    bus.cfg_addr = '0; bus.cfg_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_data_wr", DW'(bus.out_data_wr), DW'(0));
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_out_valid_wr", DW'(bus.out_valid_wr), DW'(0));
    chk("rst_out_alf", DW'(bus.out_alf), DW'(0));
    chk("rst_cfg_ack_n", DW'(bus.cfg_ack_n), DW'(1));
    chk("rst_cfg_rdata", DW'(bus.cfg_rdata), DW'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      cfg_xfer(tbl[i].rw, tbl[i].a, tbl[i].wd, rd);
      if (tbl[i].rw) chk($sformatf("reg_vec%0d_addr%0h", i, tbl[i].a), DW'(rd), DW'(tbl[i].exp));
    end

    // forwarded 3-word packet
    mon_q.delete();
    send_pkt(3, 1, 1'b1);
    wait_out(3, 30);
    repeat (5) @(posedge clk);
    check_pkt("fwd", 3, 1);
    reg_rd(8'h03, 32'(ST), "in_pkt_after_fwd");
    reg_rd(8'h04, 32'(ST), "out_pkt_after_fwd");

    // discarded packet
    mon_q.delete();
    send_pkt(3, 2, 1'b0);
    repeat (15) @(posedge clk);
    chk("discard_no_output", DW'(mon_q.size()), DW'(0));
    reg_rd(8'h05, 32'(ST), "drop_after_discard");
    reg_rd(8'h01, 32'h0, "status_after_discard");

    // downstream almost-full holds a queued packet, then latency 2
    mon_q.delete();
    @(posedge clk); #1;
    bus.in_alf = 1'b1;
    send_pkt(3, 3, 1'b1);
    repeat (10) @(posedge clk);
    chk("alf_hold_no_output", DW'(mon_q.size()), DW'(0));
    reg_rd(8'h01, 32'h1, "status_in_alf");
    @(posedge clk); #1;
    bus.in_alf = 1'b0;
    t0 = cyc;
    wait_out(3, 30);
    repeat (5) @(posedge clk);
    if (mon_q.size() > 0) chk("alf_release_latency", DW'(mon_q[0].cyc), DW'(t0 + 2));
    check_pkt("after_alf", 3, 3);

    // forced discard of two valid packets
    mon_q.delete();
    reg_wr(8'h00, 32'h1);
    send_pkt(3, 5, 1'b1);
    send_pkt(4, 6, 1'b1);
    repeat (20) @(posedge clk);
    chk("force_discard_no_output", DW'(mon_q.size()), DW'(0));
    reg_rd(8'h05, 32'(3 * ST), "drop_after_force");
    reg_rd(8'h04, 32'(2 * ST), "out_pkt_after_force");
    reg_wr(8'h00, 32'h0);

    // margin 4: almost-full at 1020 words, overflow on the 1025th
    reg_wr(8'h02, 32'h4);
    push_words(1019, 7);
    chk("alf_at_1019", DW'(bus.out_alf), DW'(0));
    push_words(1, 8);
    chk("alf_at_1020", DW'(bus.out_alf), DW'(1));
    reg_rd(8'h01, 32'h2, "status_alf");
    push_words(4, 9);
    reg_rd(8'h01, 32'h2, "status_full_no_ovf");
    push_words(1, 10);
    reg_rd(8'h01, 32'h6, "status_ovf_set");
    reg_wr(8'h01, 32'h4);
    reg_rd(8'h01, 32'h2, "status_ovf_cleared");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("reset_clears_alf", DW'(bus.out_alf), DW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    reg_rd(8'h01, 32'h0, "status_post_reset");
    reg_rd(8'h02, 32'h200, "margin_post_reset");

    // reset in the middle of SEND
    mon_q.delete();
    send_pkt(6, 11, 1'b1);
    wait_out(1, 30);
    @(posedge clk); #1;
    chk("mid_send_active", DW'(bus.out_data_wr), DW'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_data_wr", DW'(bus.out_data_wr), DW'(0));
    chk("mid_rst_out_data", bus.out_data, '0);
    chk("mid_rst_out_valid_wr", DW'(bus.out_valid_wr), DW'(0));
    chk("mid_rst_out_alf", DW'(bus.out_alf), DW'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_q.delete();
    send_pkt(3, 12, 1'b1);
    wait_out(3, 30);
    repeat (5) @(posedge clk);
    check_pkt("post_rst", 3, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
